axi_4lite: RTL and testbench
============================

Name: axi_4lite

Overview:
- AXI4-Lite slave exposing four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Serves as the reusable register-interface template.
- Sits between an AXI4-Lite master (interconnect/CPU) and user logic that consumes the register contents.
- Independent write and read channels; single outstanding transaction per channel.

Parameters:
- AXI_Dwidth, 32, data bus width in bits (byte strobes = AXI_Dwidth/8).
- AXI_Addrwidth, 4, byte address width; register index = addr[3:2].

Ports:
- AXI_aclk  in  1  clock, all logic on rising edge.
- AXI_aresetn  in  1  asynchronous active-low reset.
- AXI_awaddr  in  AXI_Addrwidth  write address.
- AXI_awvalid  in  1  write address valid.
- AXI_awready  out  1  write address accepted.
- AXI_wdata  in  AXI_Dwidth  write data.
- AXI_wstrb  in  AXI_Dwidth/8  write byte strobes.
- AXI_wvalid  in  1  write data valid.
- AXI_wready  out  1  write data accepted.
- AXI_bresp  out  2  write response.
- AXI_bvalid  out  1  write response valid.
- AXI_bready  in  1  master ready for response.
- AXI_areadaddr  in  AXI_Addrwidth  read address.
- AXI_arprotect  in  3  read protection type; accepted, ignored.
- AXI_arvalid  in  1  read address valid.
- AXI_arready  out  1  read address accepted.
- AXI_rdata  out  AXI_Dwidth  read data.
- AXI_rresp  out  2  read response.
- AXI_rvalid  out  1  read data valid.
- AXI_rready  in  1  master ready for read data.

Behaviour:
- Reset:
  - One clock; reset asynchronous, active-low (AXI_aresetn).
  - While low: all registers = 0; awready, wready, bvalid, arready, rvalid = 0; bresp = rresp = 2'b00; rdata = 0.
  - Reset asserted mid-transaction aborts it; no response is issued afterwards.
- Write acceptance:
  - When awvalid && wvalid && !awready && !bvalid: assert awready and wready together for exactly one cycle.
  - Write commits on the edge where awvalid, wvalid, awready and wready are all high.
  - Address and data are taken together; the slave never accepts one without the other.
- Write commit:
  - On the handshake edge, register[awaddr[3:2]] is updated byte-wise: byte i written iff wstrb[i].
  - Unstrobed bytes keep their value.
  - awaddr[1:0] is ignored.
- Write response:
  - bvalid rises on the cycle after the handshake with bresp = OKAY (2'b00).
  - bvalid is held until sampled with bready high, then cleared.
  - No new write is accepted while bvalid = 1.
  - Write-to-bvalid latency: 1 cycle.
- Read acceptance:
  - When arvalid && !arready && !rvalid: assert arready for exactly one cycle.
  - Capture the register index areadaddr[3:2].
- Read data:
  - On the cycle after acceptance: rdata = register[index], rresp = OKAY, rvalid = 1.
  - rvalid is held until sampled with rready high, then cleared.
  - rdata keeps its value after the handshake until the next read is accepted.
  - No new read is accepted while rvalid = 1.
- Channel independence:
  - Read and write channels operate concurrently.
  - A read accepted on the same edge as a write commit to the same register returns the pre-write value.
- Responses: all addresses are decoded (4 registers fill the space); SLVERR/DECERR are never generated.
- Register outputs: register contents are available internally; no extra ports.

Decomposition:
- Shared package axi_4lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - NUM_REGS = 4;
  - register index width = 2.
- One natural sub-module, axi_4lite_regfile: 4x32 storage with byte-strobed write port and combinational read port.
- The top-level keeps the write and read handshake FSMs:
  - write states IDLE -> RESP (on handshake) -> IDLE (on bvalid&&bready);
  - read states IDLE -> DATA (on arvalid accept) -> IDLE (on rvalid&&rready).

Test Plan:
- Reset:
  - Hold aresetn low 20 ns, release.
  - Expect all ready/valid outputs 0.
  - Read of each address 0x0/0x4/0x8/0xC returns 0x00000000.
- Full write then read:
  - awaddr=0x0, wdata=0xDEADBEEF, wstrb=4'b1111, awvalid=wvalid=bready=1.
  - Expect awready&&wready one cycle, bvalid next cycle with bresp=00.
  - Then read araddr=0x0 with rready=1: expect arready pulse, rvalid next cycle, rdata=0xDEADBEEF, rresp=00; rdata still 0xDEADBEEF one cycle after handshake.
- Byte strobes:
  - Write 0x11223344 to 0x4 with wstrb=4'b1111.
  - Then write 0xAABBCCDD with wstrb=4'b0101.
  - Read 0x4 -> 0x11BB33DD.
- Backpressure:
  - Write to 0x8 with bready=0 for 5 cycles: bvalid stays 1, a second awvalid/wvalid is not accepted; raise bready -> bvalid clears next edge.
  - Same on read with rready=0: rvalid and rdata held stable.
- Address aliasing and independence:
  - Write 0xCAFEF00D to 0xE; read 0xC -> 0xCAFEF00D.
  - Registers 0x0, 0x4, 0x8 unchanged.
- Reset mid-operation:
  - Assert aresetn low while bvalid=1 and rvalid=1.
  - Both clear immediately (asynchronously); all registers read back 0 after release.

Source files
------------

// File: rtl/axi_4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_4lite_pkg
// Shared definitions for the AXI4-Lite register slave:
//   - AXI response codes
//   - register count and register index width
//   - state encodings for the write and read handshake FSMs
// ---------------------------------------------------------------------------
package axi_4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int NUM_REGS  = 4;
   localparam int REG_IDX_W = 2;

   // WR_ACCEPT is the single cycle in which awready/wready are driven high.
   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_ACCEPT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_e;

   // RD_ACCEPT is the single cycle in which arready is driven high.
   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_ACCEPT = 2'd1,
      RD_DATA   = 2'd2
   } rd_state_e;

endpackage

// File: rtl/axi_4lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_4lite_regfile
// NUM_REGS x DW register storage with one byte-strobed write port and one
// combinational read port. Contents clear on reset.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en               commit a write this cycle
//   wr_idx              register index to write
//   wr_data, wr_strb    write data and per-byte write enables
//   rd_idx              register index to read
//   rd_data             contents of register rd_idx (combinational)
// ---------------------------------------------------------------------------
module axi_4lite_regfile
   import axi_4lite_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [REG_IDX_W-1:0] wr_idx,
   input  logic [DW-1:0]        wr_data,
   input  logic [DW/8-1:0]      wr_strb,
   input  logic [REG_IDX_W-1:0] rd_idx,
   output logic [DW-1:0]        rd_data
);

   localparam int NUM_BYTES = DW / 8;

   // Flattened view of all registers, used by the read mux.
   logic [NUM_REGS-1:0][DW-1:0] regs_all;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DW-1:0] reg_q;
         logic [DW-1:0] reg_d;

         always_comb begin
            reg_d = reg_q;
            if (wr_en && (wr_idx == REG_IDX_W'(gi))) begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (wr_strb[b]) begin
                     reg_d[b*8 +: 8] = wr_data[b*8 +: 8];
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reg_q <= '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign regs_all[gi] = reg_q;
      end
   endgenerate

   assign rd_data = regs_all[rd_idx];

endmodule

// File: rtl/axi_4lite.sv
// ---------------------------------------------------------------------------
// axi_4lite
// AXI4-Lite slave with four 32-bit read/write registers at byte offsets
// 0x0, 0x4, 0x8, 0xC (index = address bits [3:2]). Write and read channels
// run independently, one outstanding transaction each. Every access gets
// an OKAY response.
// Ports:
//   AXI_aclk, AXI_aresetn                  clock, async active-low reset
//   AXI_awaddr/awvalid/awready             write address channel
//   AXI_wdata/wstrb/wvalid/wready          write data channel
//   AXI_bresp/bvalid/bready                write response channel
//   AXI_areadaddr/arprotect/arvalid/arready read address channel
//   AXI_rdata/rresp/rvalid/rready          read data channel
// ---------------------------------------------------------------------------
module axi_4lite
   import axi_4lite_pkg::*;
#(
   parameter int AXI_Dwidth    = 32,
   parameter int AXI_Addrwidth = 4
) (
   input  logic                      AXI_aclk,
   input  logic                      AXI_aresetn,
   input  logic [AXI_Addrwidth-1:0]  AXI_awaddr,
   input  logic                      AXI_awvalid,
   output logic                      AXI_awready,
   input  logic [AXI_Dwidth-1:0]     AXI_wdata,
   input  logic [AXI_Dwidth/8-1:0]   AXI_wstrb,
   input  logic                      AXI_wvalid,
   output logic                      AXI_wready,
   output logic [1:0]                AXI_bresp,
   output logic                      AXI_bvalid,
   input  logic                      AXI_bready,
   input  logic [AXI_Addrwidth-1:0]  AXI_areadaddr,
   input  logic [2:0]                AXI_arprotect,
   input  logic                      AXI_arvalid,
   output logic                      AXI_arready,
   output logic [AXI_Dwidth-1:0]     AXI_rdata,
   output logic [1:0]                AXI_rresp,
   output logic                      AXI_rvalid,
   input  logic                      AXI_rready
);

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic [AXI_Dwidth-1:0] rdata_q, rdata_d;
   logic                  wr_commit;
   logic [AXI_Dwidth-1:0] rf_rdata;

   // Byte-lane bits, address bits above the register index, and the
   // protection type carry no meaning for this slave.
   logic unused_ok;
   assign unused_ok = ^{AXI_arprotect, AXI_awaddr, AXI_areadaddr};

   axi_4lite_regfile #(
      .DW (AXI_Dwidth)
   ) u_regfile (
      .clk     (AXI_aclk),
      .rst_n   (AXI_aresetn),
      .wr_en   (wr_commit),
      .wr_idx  (AXI_awaddr[REG_IDX_W+1:2]),
      .wr_data (AXI_wdata),
      .wr_strb (AXI_wstrb),
      .rd_idx  (AXI_areadaddr[REG_IDX_W+1:2]),
      .rd_data (rf_rdata)
   );

   // ---------------- write channel ----------------
   // Address and data are only accepted together, so the FSM waits for
   // both valids before raising the two readies in the same cycle.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_commit  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (AXI_awvalid && AXI_wvalid) begin
               wr_state_d = WR_ACCEPT;
            end
         end
         WR_ACCEPT: begin
            if (AXI_awvalid && AXI_wvalid) begin
               wr_commit  = 1'b1;
               wr_state_d = WR_RESP;
            end else begin
               // Master withdrew the request; drop back without writing.
               wr_state_d = WR_IDLE;
            end
         end
         WR_RESP: begin
            if (AXI_bready) begin
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) begin
         wr_state_q <= WR_IDLE;
      end else begin
         wr_state_q <= wr_state_d;
      end
   end

   assign AXI_awready = (wr_state_q == WR_ACCEPT);
   assign AXI_wready  = (wr_state_q == WR_ACCEPT);
   assign AXI_bvalid  = (wr_state_q == WR_RESP);
   assign AXI_bresp   = RESP_OKAY;

   // ---------------- read channel ----------------
   // Read data is sampled from the register file on the handshake edge, so
   // a write committing on that same edge is not yet visible.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (AXI_arvalid) begin
               rd_state_d = RD_ACCEPT;
            end
         end
         RD_ACCEPT: begin
            if (AXI_arvalid) begin
               rdata_d    = rf_rdata;
               rd_state_d = RD_DATA;
            end else begin
               rd_state_d = RD_IDLE;
            end
         end
         RD_DATA: begin
            if (AXI_rready) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) begin
         rd_state_q <= RD_IDLE;
         rdata_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
      end
   end

   assign AXI_arready = (rd_state_q == RD_ACCEPT);
   assign AXI_rvalid  = (rd_state_q == RD_DATA);
   assign AXI_rdata   = rdata_q;
   assign AXI_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_4lite.sv
// ---------------------------------------------------------------------------
// tb_axi_4lite
// Self-checking bench for the AXI4-Lite register slave: a table of
// write/read transactions with hand-computed expected data, followed by
// hand-written sequences for backpressure, simultaneous read/write to the
// same register, and reset in the middle of outstanding responses.
// ---------------------------------------------------------------------------
module tb_axi_4lite;

   logic        clk;
   logic        rst_n;
   logic [3:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_fail   = 0;

   axi_4lite #(
      .AXI_Dwidth    (32),
      .AXI_Addrwidth (4)
   ) dut (
      .AXI_aclk      (clk),
      .AXI_aresetn   (rst_n),
      .AXI_awaddr    (awaddr),
      .AXI_awvalid   (awvalid),
      .AXI_awready   (awready),
      .AXI_wdata     (wdata),
      .AXI_wstrb     (wstrb),
      .AXI_wvalid    (wvalid),
      .AXI_wready    (wready),
      .AXI_bresp     (bresp),
      .AXI_bvalid    (bvalid),
      .AXI_bready    (bready),
      .AXI_areadaddr (araddr),
      .AXI_arprotect (arprot),
      .AXI_arvalid   (arvalid),
      .AXI_arready   (arready),
      .AXI_rdata     (rdata),
      .AXI_rresp     (rresp),
      .AXI_rvalid    (rvalid),
      .AXI_rready    (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise a write request and wait (bounded) for the acceptance pulse.
   // Returns the number of cycles it took.
   task automatic wait_awready(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!awready && cycles < 8);
   endtask

   task automatic wait_arready(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!arready && cycles < 8);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int cyc;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      wait_awready(cyc);
      chk($sformatf("wr@%0h aw_latency", a), 32'(cyc), 32'd1);
      chk($sformatf("wr@%0h awready", a), 32'(awready), 32'd1);
      chk($sformatf("wr@%0h wready", a), 32'(wready), 32'd1);
      chk($sformatf("wr@%0h bvalid_early", a), 32'(bvalid), 32'd0);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk($sformatf("wr@%0h awready_pulse", a), 32'(awready), 32'd0);
      chk($sformatf("wr@%0h bvalid", a), 32'(bvalid), 32'd1);
      chk($sformatf("wr@%0h bresp", a), 32'(bresp), 32'd0);
      tick();
      chk($sformatf("wr@%0h bvalid_clear", a), 32'(bvalid), 32'd0);
      $display("WRITE addr=0x%0h data=0x%08h strb=%b", a, d, s);
   endtask

   task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
      int cyc;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      wait_arready(cyc);
      chk($sformatf("rd@%0h ar_latency", a), 32'(cyc), 32'd1);
      chk($sformatf("rd@%0h arready", a), 32'(arready), 32'd1);
      chk($sformatf("rd@%0h rvalid_early", a), 32'(rvalid), 32'd0);
      tick();
      arvalid = 1'b0;
      chk($sformatf("rd@%0h arready_pulse", a), 32'(arready), 32'd0);
      chk($sformatf("rd@%0h rvalid", a), 32'(rvalid), 32'd1);
      chk($sformatf("rd@%0h rdata", a), rdata, exp);
      chk($sformatf("rd@%0h rresp", a), 32'(rresp), 32'd0);
      tick();
      chk($sformatf("rd@%0h rvalid_clear", a), 32'(rvalid), 32'd0);
      chk($sformatf("rd@%0h rdata_hold", a), rdata, exp);
      $display("READ  addr=0x%0h data=0x%08h expected=0x%08h", a, rdata, exp);
   endtask

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [31:0] data;   // write data, or expected read data
      logic [3:0]  strb;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      int cyc;

      vecs[0]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0};
      vecs[1]  = '{1'b0, 4'h4, 32'h0000_0000, 4'h0};
      vecs[2]  = '{1'b0, 4'h8, 32'h0000_0000, 4'h0};
      vecs[3]  = '{1'b0, 4'hC, 32'h0000_0000, 4'h0};
      vecs[4]  = '{1'b1, 4'h0, 32'hDEAD_BEEF, 4'b1111};
      vecs[5]  = '{1'b0, 4'h0, 32'hDEAD_BEEF, 4'h0};
      vecs[6]  = '{1'b1, 4'h4, 32'h1122_3344, 4'b1111};
      vecs[7]  = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'b0101};
      vecs[8]  = '{1'b0, 4'h4, 32'h11BB_33DD, 4'h0};
      vecs[9]  = '{1'b1, 4'hE, 32'hCAFE_F00D, 4'b1111};
      vecs[10] = '{1'b0, 4'hC, 32'hCAFE_F00D, 4'h0};
      vecs[11] = '{1'b0, 4'h0, 32'hDEAD_BEEF, 4'h0};
      vecs[12] = '{1'b0, 4'h4, 32'h11BB_33DD, 4'h0};
      vecs[13] = '{1'b0, 4'h8, 32'h0000_0000, 4'h0};
      vecs[14] = '{1'b1, 4'h1, 32'h0000_00FF, 4'b0001};   // low addr bits ignored
      vecs[15] = '{1'b0, 4'h0, 32'hDEAD_BEFF, 4'h0};
      vecs[16] = '{1'b1, 4'h9, 32'h12FF_FFFF, 4'b1000};   // top byte of reg 2 only

      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;

      // ---- reset ----
      #12;
      chk("rst awready", 32'(awready), 32'd0);
      chk("rst wready", 32'(wready), 32'd0);
      chk("rst bvalid", 32'(bvalid), 32'd0);
      chk("rst arready", 32'(arready), 32'd0);
      chk("rst rvalid", 32'(rvalid), 32'd0);
      chk("rst rdata", rdata, 32'd0);
      #8;
      rst_n = 1'b1;
      tick();
      chk("post_rst bvalid", 32'(bvalid), 32'd0);
      chk("post_rst rvalid", 32'(rvalid), 32'd0);
      $display("RESET released");

      // ---- table-driven transactions ----
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         end else begin
            do_read(vecs[i].addr, vecs[i].data);
         end
      end
      do_read(4'h8, 32'h1200_0000);

      // ---- write backpressure ----
      awaddr = 4'h8; wdata = 32'h0BAD_CAFE; wstrb = 4'b1111;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      wait_awready(cyc);
      chk("wbp awready", 32'(awready), 32'd1);
      tick();
      // Present a second write to reg 0 that must not be accepted.
      awaddr = 4'h0; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wbp bvalid_hold[%0d]", i), 32'(bvalid), 32'd1);
         chk($sformatf("wbp no_accept[%0d]", i), 32'(awready | wready), 32'd0);
         tick();
      end
      bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wbp bvalid_clear", 32'(bvalid), 32'd0);
      $display("WRITE backpressure addr=0x8 data=0x0bad_cafe");
      do_read(4'h8, 32'h0BAD_CAFE);
      do_read(4'h0, 32'hDEAD_BEFF);

      // ---- read backpressure ----
      araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
      wait_arready(cyc);
      chk("rbp arready", 32'(arready), 32'd1);
      tick();
      araddr = 4'h4;   // second read must wait
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rbp rvalid_hold[%0d]", i), 32'(rvalid), 32'd1);
         chk($sformatf("rbp rdata_hold[%0d]", i), rdata, 32'h0BAD_CAFE);
         chk($sformatf("rbp no_accept[%0d]", i), 32'(arready), 32'd0);
         tick();
      end
      rready = 1'b1;
      tick();
      arvalid = 1'b0;
      chk("rbp rvalid_clear", 32'(rvalid), 32'd0);
      chk("rbp rdata_after", rdata, 32'h0BAD_CAFE);
      $display("READ  backpressure addr=0x8 data=0x%08h", rdata);

      // ---- read and write to the same register on the same edge ----
      awaddr = 4'hC; wdata = 32'h55AA_55AA; wstrb = 4'b1111;
      araddr = 4'hC; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      bready = 1'b1; rready = 1'b1;
      wait_awready(cyc);
      chk("same awready", 32'(awready), 32'd1);
      chk("same arready", 32'(arready), 32'd1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("same bvalid", 32'(bvalid), 32'd1);
      chk("same rvalid", 32'(rvalid), 32'd1);
      chk("same rdata_old", rdata, 32'hCAFE_F00D);
      tick();
      $display("RDWR  same-edge addr=0xC read=0x%08h", rdata);
      do_read(4'hC, 32'h55AA_55AA);

      // ---- reset with both responses outstanding ----
      awaddr = 4'h4; wdata = 32'h7777_7777; wstrb = 4'b1111;
      araddr = 4'h0; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      bready = 1'b0; rready = 1'b0;
      wait_awready(cyc);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("mid bvalid_pending", 32'(bvalid), 32'd1);
      chk("mid rvalid_pending", 32'(rvalid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid bvalid_async", 32'(bvalid), 32'd0);
      chk("mid rvalid_async", 32'(rvalid), 32'd0);
      chk("mid rdata_async", rdata, 32'd0);
      #20;
      rst_n = 1'b1;
      bready = 1'b1; rready = 1'b1;
      tick();
      chk("mid no_bvalid", 32'(bvalid), 32'd0);
      chk("mid no_rvalid", 32'(rvalid), 32'd0);
      $display("RESET mid-transaction");
      for (int r = 0; r < 4; r++) begin
         do_read(4'(r * 4), 32'h0000_0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
